// File: rtl/sha_mainloop_ctrl.sv
// SHA compression main-loop sequencer: accepts a block job, streams W/K into
// the round datapath one round per cycle, feeds the datapath result back into
// the working state and adds the result onto the chaining hash at the end.

package sha;
    typedef enum logic [1:0] {
        MODE_SHA1   = 2'd0,
        MODE_SHA224 = 2'd1,
        MODE_SHA256 = 2'd2
    } mode_t;
endpackage

module sha_mainloop_ctrl #(
    parameter int WORD_W  = 32,
    parameter int STATE_W = 256
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start_valid,
    output logic               start_ready,
    input  sha::mode_t         start_mode,
    input  logic [STATE_W-1:0] hash_in,
    input  logic               abort,
    input  logic               w_valid,
    output logic               w_ready,
    input  logic [WORD_W-1:0]  w_data,
    output logic [6:0]         k_addr,
    input  logic [WORD_W-1:0]  k_data,
    output logic               ml_enable,
    output sha::mode_t         ml_mode,
    output logic [1:0]         ml_ft,
    output logic [WORD_W-1:0]  ml_k,
    output logic [WORD_W-1:0]  ml_w,
    output logic [STATE_W-1:0] ml_raw,
    input  logic [STATE_W-1:0] ml_ripe,
    output logic               hash_valid,
    input  logic               hash_ready,
    output logic [STATE_W-1:0] hash_out
);

    localparam int NWORDS     = STATE_W / WORD_W;
    // SHA-1 carries five words, held in the upper part of the state
    localparam int SHA1_WORDS = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    sha::mode_t         mode_q;
    logic [STATE_W-1:0] hash_q;
    logic [STATE_W-1:0] raw_q;
    logic [STATE_W-1:0] hout_q;
    logic [STATE_W-1:0] sum;
    logic [6:0]         t_q;
    logic               last_round;
    logic               consume;

    // A round is consumed only when a word is present and no cancel is pending
    assign consume     = (state == ROUND) && w_valid && !abort;
    assign w_ready     = consume;
    assign ml_enable   = consume;

    assign start_ready = (state == IDLE);
    assign hash_valid  = (state == DONE);
    assign k_addr      = t_q;
    assign ml_mode     = mode_q;
    assign ml_k        = k_data;
    assign ml_w        = w_data;
    assign ml_raw      = raw_q;
    assign hash_out    = hout_q;

    assign last_round  = (mode_q == sha::MODE_SHA1) ? (t_q == 7'd79) : (t_q == 7'd63);

    // SHA-1 boolean function select: one step every 20 rounds
    always_comb begin
        ml_ft = 2'd0;
        if (mode_q == sha::MODE_SHA1) begin
            if (t_q >= 7'd60)
                ml_ft = 2'd3;
            else if (t_q >= 7'd40)
                ml_ft = 2'd2;
            else if (t_q >= 7'd20)
                ml_ft = 2'd1;
        end
    end

    // Word-wise modular addition of working state onto the chaining hash
    always_comb begin
        sum = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (mode_q != sha::MODE_SHA1 || i >= NWORDS - SHA1_WORDS)
                sum[i*WORD_W +: WORD_W] = hash_q[i*WORD_W +: WORD_W] + raw_q[i*WORD_W +: WORD_W];
        end
    end

    // Next-state selection; abort outranks every other transition
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_valid) state_nxt = ROUND;
            ROUND: begin
                if (abort)
                    state_nxt = IDLE;
                else if (w_valid && last_round)
                    state_nxt = FINAL;
            end
            FINAL:   state_nxt = abort ? IDLE : DONE;
            DONE:    if (abort || hash_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Job latch, working state, round counter and result register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_q <= sha::MODE_SHA1;
            hash_q <= '0;
            raw_q  <= '0;
            hout_q <= '0;
            t_q    <= 7'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        mode_q <= start_mode;
                        hash_q <= hash_in;
                        raw_q  <= hash_in;
                        t_q    <= 7'd0;
                    end
                end
                ROUND: begin
                    if (consume) begin
                        raw_q <= ml_ripe;
                        t_q   <= t_q + 7'd1;
                    end
                end
                FINAL: begin
                    if (!abort)
                        hout_q <= sum;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha_mainloop_ctrl.sv
// Testbench for sha_mainloop_ctrl: provides the K ROM, the message schedule
// and the round datapath around the controller, and checks digests against a
// plain SHA-1 / SHA-256 compression model.

module tb_sha_mainloop_ctrl;
    import sha::*;

    localparam int WORD_W  = 32;
    localparam int STATE_W = 256;

    localparam logic [31:0] K256 [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] K1 [4] = '{32'h5a827999, 32'h6ed9eba1, 32'h8f1bbcdc, 32'hca62c1d6};

    localparam logic [255:0] IV256  = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                       32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [255:0] IV1    = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476,
                                       32'hc3d2e1f0, 96'h0};
    localparam logic [255:0] DIG256 = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                       32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    localparam logic [255:0] DIG1   = {32'ha9993e36, 32'h4706816a, 32'hba3e2571, 32'h7850c26c,
                                       32'h9cd0d89d, 96'h0};
    localparam logic [511:0] ABC    = {32'h61626380, 448'h0, 32'h00000018};

    logic               clk = 1'b0;
    logic               rstn;
    logic               start_valid;
    logic               start_ready;
    mode_t              start_mode;
    logic [STATE_W-1:0] hash_in;
    logic               abort;
    logic               w_valid;
    logic               w_ready;
    logic [WORD_W-1:0]  w_data;
    logic [6:0]         k_addr;
    logic [WORD_W-1:0]  k_data;
    logic               ml_enable;
    mode_t              ml_mode;
    logic [1:0]         ml_ft;
    logic [WORD_W-1:0]  ml_k;
    logic [WORD_W-1:0]  ml_w;
    logic [STATE_W-1:0] ml_raw;
    logic [STATE_W-1:0] ml_ripe;
    logic               hash_valid;
    logic               hash_ready;
    logic [STATE_W-1:0] hash_out;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] w_sched [80];
    mode_t       env_mode = MODE_SHA256;

    sha_mainloop_ctrl #(.WORD_W(WORD_W), .STATE_W(STATE_W)) dut (
        .clk(clk), .rstn(rstn),
        .start_valid(start_valid), .start_ready(start_ready), .start_mode(start_mode),
        .hash_in(hash_in), .abort(abort),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .k_addr(k_addr), .k_data(k_data),
        .ml_enable(ml_enable), .ml_mode(ml_mode), .ml_ft(ml_ft), .ml_k(ml_k), .ml_w(ml_w),
        .ml_raw(ml_raw), .ml_ripe(ml_ripe),
        .hash_valid(hash_valid), .hash_ready(hash_ready), .hash_out(hash_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return rotr(x, 32 - n);
    endfunction

    function automatic logic [31:0] kfor(input mode_t m, input int t);
        if (m == MODE_SHA1)
            return (t < 80) ? K1[t / 20] : 32'h0;
        return (t < 64) ? K256[t] : 32'h0;
    endfunction

    // One compression round as the external datapath computes it
    function automatic logic [255:0] round_fn(input mode_t m, input logic [1:0] ft,
                                              input logic [255:0] s, input logic [31:0] w,
                                              input logic [31:0] k);
        logic [31:0] a, b, c, d, e, f, g, h, fv, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        if (m == MODE_SHA1) begin
            case (ft)
                2'd0:    fv = (b & c) | (~b & d);
                2'd2:    fv = (b & c) | (b & d) | (c & d);
                default: fv = b ^ c ^ d;
            endcase
            t1 = rotl(a, 5) + fv + e + k + w;
            return {t1, a, rotl(b, 30), c, d, s[95:0]};
        end
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    // Message schedule expansion for one 512-bit block
    task automatic fill_schedule(input mode_t m, input logic [511:0] blk);
        logic [31:0] s0, s1;
        for (int i = 0; i < 16; i++)
            w_sched[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 80; i++) begin
            if (m == MODE_SHA1) begin
                w_sched[i] = rotl(w_sched[i-3] ^ w_sched[i-8] ^ w_sched[i-14] ^ w_sched[i-16], 1);
            end else begin
                s0 = rotr(w_sched[i-15], 7) ^ rotr(w_sched[i-15], 18) ^ (w_sched[i-15] >> 3);
                s1 = rotr(w_sched[i-2], 17) ^ rotr(w_sched[i-2], 19) ^ (w_sched[i-2] >> 10);
                w_sched[i] = w_sched[i-16] + s0 + w_sched[i-7] + s1;
            end
        end
    endtask

    // Whole-block reference compression including the final feed-forward add
    function automatic logic [255:0] ref_compress(input mode_t m, input logic [255:0] h);
        logic [31:0]  v [8];
        logic [31:0]  fv, tmp, t1, t2;
        logic [255:0] dig = '0;
        for (int i = 0; i < 8; i++)
            v[i] = h[255 - 32*i -: 32];
        if (m == MODE_SHA1) begin
            for (int t = 0; t < 80; t++) begin
                if (t < 20)      fv = (v[1] & v[2]) | (~v[1] & v[3]);
                else if (t < 40) fv = v[1] ^ v[2] ^ v[3];
                else if (t < 60) fv = (v[1] & v[2]) | (v[1] & v[3]) | (v[2] & v[3]);
                else             fv = v[1] ^ v[2] ^ v[3];
                tmp  = rotl(v[0], 5) + fv + v[4] + K1[t / 20] + w_sched[t];
                v[4] = v[3]; v[3] = v[2]; v[2] = rotl(v[1], 30); v[1] = v[0]; v[0] = tmp;
            end
            for (int i = 0; i < 5; i++)
                dig[255 - 32*i -: 32] = h[255 - 32*i -: 32] + v[i];
        end else begin
            for (int t = 0; t < 64; t++) begin
                t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
                     + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K256[t] + w_sched[t];
                t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
                     + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
                for (int j = 7; j > 0; j--)
                    v[j] = v[j-1];
                v[4] = v[4] + t1;
                v[0] = t1 + t2;
            end
            for (int i = 0; i < 8; i++)
                dig[255 - 32*i -: 32] = h[255 - 32*i -: 32] + v[i];
        end
        return dig;
    endfunction

    // K ROM driven by the round index
    always_comb k_data = kfor(env_mode, int'(k_addr));

    // Round datapath feeding the next working state back
    always_comb ml_ripe = round_fn(ml_mode, ml_ft, ml_raw, ml_w, ml_k);

    task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // pattern: 0 always valid, 1 bubble/valid alternating, 2 random
    // stop_kind: 0 none, 1 abort at round stop_at, 2 reset at round stop_at
    task automatic applyStimulus(input mode_t m, input logic [255:0] h_in, input logic [511:0] blk,
                                 input int pattern, input int stop_kind, input int stop_at,
                                 input int hold, input int exp_lat,
                                 input logic [255:0] const_dig, input bit use_const);
        int           n = (m == MODE_SHA1) ? 80 : 64;
        int           widx = 0;
        int           cyc = 0;
        int           last_edge = 0;
        int           done_edge = -1;
        bit           wv;
        logic [255:0] exp_raw = h_in;
        logic [255:0] exp_dig;

        env_mode = m;
        fill_schedule(m, blk);
        exp_dig = use_const ? const_dig : ref_compress(m, h_in);

        @(negedge clk);
        start_valid = 1'b1;
        start_mode  = m;
        hash_in     = h_in;
        hash_ready  = 1'b0;
        w_valid     = 1'b0;
        abort       = 1'b0;
        #1;
        checkOutput("start_ready_idle", 256'(start_ready), 256'(1));
        @(posedge clk);

        while (widx < n && cyc < 400) begin
            @(negedge clk);
            start_valid = 1'b0;
            hash_in     = {$urandom(), $urandom(), $urandom(), $urandom(),
                           $urandom(), $urandom(), $urandom(), $urandom()};
            case (pattern)
                0:       wv = 1'b1;
                1:       wv = (cyc % 2 == 1);
                default: wv = ($urandom_range(0, 2) != 0);
            endcase
            if (stop_kind == 1 && widx == stop_at) begin
                wv    = 1'b1;
                abort = 1'b1;
            end
            if (stop_kind == 2 && widx == stop_at)
                rstn = 1'b0;
            w_valid = wv;
            w_data  = w_sched[widx];
            #1;
            if (stop_kind == 2 && widx == stop_at) begin
                checkOutput("rst_start_ready", 256'(start_ready), 256'(1));
                checkOutput("rst_hash_valid", 256'(hash_valid), 256'(0));
                checkOutput("rst_ml_enable", 256'(ml_enable), 256'(0));
                checkOutput("rst_w_ready", 256'(w_ready), 256'(0));
                checkOutput("rst_k_addr", 256'(k_addr), 256'(0));
                checkOutput("rst_ml_ft", 256'(ml_ft), 256'(0));
                checkOutput("rst_ml_raw", ml_raw, 256'(0));
                checkOutput("rst_hash_out", hash_out, 256'(0));
                @(posedge clk);
                @(negedge clk);
                rstn    = 1'b1;
                w_valid = 1'b0;
                #1;
                checkOutput("rst_release_ready", 256'(start_ready), 256'(1));
                return;
            end
            if (stop_kind == 1 && widx == stop_at) begin
                checkOutput("abort_w_ready", 256'(w_ready), 256'(0));
                checkOutput("abort_ml_enable", 256'(ml_enable), 256'(0));
                @(posedge clk);
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    abort   = 1'b0;
                    w_valid = 1'b0;
                    #1;
                    checkOutput("abort_start_ready", 256'(start_ready), 256'(1));
                    checkOutput("abort_hash_valid", 256'(hash_valid), 256'(0));
                end
                return;
            end
            checkOutput("w_ready", 256'(w_ready), 256'(wv));
            checkOutput("ml_enable", 256'(ml_enable), 256'(wv));
            checkOutput("k_addr", 256'(k_addr), 256'(widx));
            checkOutput("ml_ft", 256'(ml_ft), 256'((m == MODE_SHA1) ? widx / 20 : 0));
            if (!wv || widx == 0)
                checkOutput("ml_raw", ml_raw, exp_raw);
            @(posedge clk);
            cyc++;
            if (wv) begin
                exp_raw   = round_fn(m, 2'((m == MODE_SHA1) ? widx / 20 : 0), exp_raw,
                                     w_sched[widx], kfor(m, widx));
                widx++;
                last_edge = cyc;
            end
        end

        while (done_edge < 0 && cyc < last_edge + 10) begin
            @(negedge clk);
            w_valid = 1'b0;
            #1;
            if (hash_valid)
                done_edge = cyc;
            else begin
                @(posedge clk);
                cyc++;
            end
        end
        checkOutput("latency", 256'(done_edge), 256'((exp_lat >= 0) ? exp_lat : last_edge + 1));
        if (done_edge < 0)
            return;

        for (int i = 0; i < hold; i++) begin
            checkOutput("hold_hash_valid", 256'(hash_valid), 256'(1));
            checkOutput("hold_start_ready", 256'(start_ready), 256'(0));
            checkOutput("hold_hash_out", hash_out, exp_dig);
            start_valid = 1'b1;
            start_mode  = MODE_SHA256;
            @(posedge clk);
            @(negedge clk);
            #1;
        end
        start_valid = 1'b0;
        checkOutput("done_hash_valid", 256'(hash_valid), 256'(1));
        checkOutput("digest", hash_out, exp_dig);
        hash_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        hash_ready = 1'b0;
        #1;
        checkOutput("release_hash_valid", 256'(hash_valid), 256'(0));
        checkOutput("release_start_ready", 256'(start_ready), 256'(1));
    endtask

    initial begin
        logic [511:0] blk;
        logic [255:0] hv;
        mode_t        m;

        rstn        = 1'b1;
        start_valid = 1'b0;
        start_mode  = MODE_SHA256;
        hash_in     = '0;
        abort       = 1'b0;
        w_valid     = 1'b0;
        w_data      = '0;
        hash_ready  = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("reset_start_ready", 256'(start_ready), 256'(1));
        checkOutput("reset_hash_valid", 256'(hash_valid), 256'(0));
        checkOutput("reset_ml_enable", 256'(ml_enable), 256'(0));
        checkOutput("reset_k_addr", 256'(k_addr), 256'(0));
        checkOutput("reset_ml_raw", ml_raw, 256'(0));
        checkOutput("reset_hash_out", hash_out, 256'(0));
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checkOutput("reset_release_ready", 256'(start_ready), 256'(1));

        applyStimulus(MODE_SHA256, IV256, ABC, 0, 0, 0, 2, 65, DIG256, 1'b1);
        applyStimulus(MODE_SHA1, IV1, ABC, 0, 0, 0, 2, 81, DIG1, 1'b1);
        applyStimulus(MODE_SHA256, IV256, ABC, 1, 0, 0, 10, 129, DIG256, 1'b1);
        applyStimulus(MODE_SHA256, IV256, ABC, 2, 1, 30, 0, -1, DIG256, 1'b1);
        applyStimulus(MODE_SHA256, IV256, ABC, 0, 0, 0, 1, 65, DIG256, 1'b1);
        applyStimulus(MODE_SHA1, IV1, ABC, 0, 2, 10, 0, -1, DIG1, 1'b1);
        applyStimulus(MODE_SHA1, IV1, ABC, 2, 0, 0, 1, -1, DIG1, 1'b1);

        for (int j = 0; j < 6; j++) begin
            for (int i = 0; i < 16; i++)
                blk[32*i +: 32] = $urandom();
            for (int i = 0; i < 8; i++)
                hv[32*i +: 32] = $urandom();
            m = mode_t'(2'($urandom_range(0, 2)));
            applyStimulus(m, hv, blk, 2, 0, 0, int'($urandom_range(0, 3)), -1, 256'(0), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
